// File: rtl/round_timer_pkg.sv
// Shared types for the number-guessing game timer: FSM state encoding and
// difficulty select type.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int unsigned DIFF_LEVELS = 4;

  typedef logic [$clog2(DIFF_LEVELS)-1:0] difficulty_t;

endpackage : game_pkg

// File: rtl/round_timer_tick_prescaler.sv
// Divides the clock into count steps: tick is high in the enabled cycle in
// which the phase counter wraps from TICK_DIV-1 back to 0.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] phase_q, phase_d;

  assign tick = en && (phase_q == PW'(TICK_DIV - 1));

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = tick ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule : tick_prescaler

// File: rtl/round_timer.sv
// Round timer: start/stop/pause FSM, difficulty-selected terminal count,
// up/down counter stepped by the prescaler, expiry pulse and low-time warning.
module round_timer #(
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned DIFF_W    = 2,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned LIMIT_D0  = 15,
  parameter int unsigned LIMIT_D1  = 31,
  parameter int unsigned LIMIT_D2  = 63,
  parameter int unsigned LIMIT_D3  = 99,
  parameter int unsigned WARN_LEFT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              count_down,
  input  logic [DIFF_W-1:0] difficulty,
  output logic [CNT_W-1:0]  counter,
  output logic              running,
  output logic              expired,
  output logic              time_up,
  output logic              warn
);

  import game_pkg::*;

  localparam logic [CNT_W-1:0] LIMITS [DIFF_LEVELS] = '{
    CNT_W'(LIMIT_D0), CNT_W'(LIMIT_D1), CNT_W'(LIMIT_D2), CNT_W'(LIMIT_D3)
  };

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             time_up_q, time_up_d;
  logic             warn_q, warn_d;

  logic [CNT_W-1:0] limit_sel;
  logic [CNT_W-1:0] terminal;
  logic [CNT_W-1:0] stepped;
  logic [CNT_W-1:0] remaining;
  logic             active;
  logic             tick;

  assign limit_sel = LIMITS[difficulty_t'(difficulty)];
  assign terminal  = dir_q ? '0 : limit_q;
  assign stepped   = dir_q ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);

  // A PAUSE cycle with pause already released counts as a run cycle, so the
  // prescaler phase loses no cycle on resume.
  assign active = !start && !stop && !pause &&
                  ((state_q == RUN) || (state_q == PAUSE));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(start),
    .en   (active),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    dir_d     = dir_q;
    expired_d = 1'b0;

    if (start) begin
      state_d = RUN;
      limit_d = limit_sel;
      dir_d   = count_down;
      cnt_d   = count_down ? limit_sel : '0;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            // A zero limit loads an already-terminal value; expire without stepping.
            if (cnt_q == terminal) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else if (tick) begin
              cnt_d = stepped;
              if (stepped == terminal) begin
                state_d   = DONE;
                expired_d = 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end

    running_d = (state_d == RUN) || (state_d == PAUSE);
    time_up_d = (state_d == DONE);
    remaining = dir_d ? cnt_d : limit_d - cnt_d;
    warn_d    = running_d && (remaining <= CNT_W'(WARN_LEFT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      limit_q   <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      expired_q <= expired_d;
      time_up_q <= time_up_d;
      warn_q    <= warn_d;
    end
  end

  assign counter = cnt_q;
  assign running = running_q;
  assign expired = expired_q;
  assign time_up = time_up_q;
  assign warn    = warn_q;

endmodule : round_timer

// File: tb/tb_round_timer.sv
// Scoreboard bench for round_timer: a round-level model (elapsed active cycles
// divided by the step period) predicts every registered output each cycle.
module tb_round_timer;

  localparam int TD   = 4;
  localparam int WARN = 5;
  localparam int LIM [4] = '{15, 31, 63, 0};

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, count_down;
  logic [1:0] difficulty;
  logic [6:0] counter;
  logic       running, expired, time_up, warn;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    int run;
    int exp;
    int tu;
    int warn;
  } exp_t;

  exp_t q[$];

  // Round-level model: mode 0 idle, 1 round in progress, 2 time over.
  int m_mode, m_limit, m_dir, m_active, m_cnt, m_exp;

  always #5 clk = ~clk;

  round_timer #(
    .CNT_W    (7),
    .DIFF_W   (2),
    .TICK_DIV (TD),
    .LIMIT_D0 (15),
    .LIMIT_D1 (31),
    .LIMIT_D2 (63),
    .LIMIT_D3 (0),
    .WARN_LEFT(WARN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .count_down(count_down),
    .difficulty(difficulty),
    .counter   (counter),
    .running   (running),
    .expired   (expired),
    .time_up   (time_up),
    .warn      (warn)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_limit = 0; m_dir = 0; m_active = 0; m_cnt = 0; m_exp = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit pa,
                            input bit cd, input int df);
    int k;
    m_exp = 0;
    if (st) begin
      m_mode   = 1;
      m_limit  = LIM[df];
      m_dir    = cd;
      m_active = 0;
      m_cnt    = cd ? m_limit : 0;
    end else if (sp) begin
      m_mode = 0;
    end else if (m_mode == 1 && !pa) begin
      m_active++;
      k = m_active / TD;
      if (k > m_limit) k = m_limit;
      m_cnt = m_dir ? m_limit - k : k;
      if (k >= m_limit) begin
        m_mode = 2;
        m_exp  = 1;
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int rem;
    rem    = m_dir ? m_cnt : m_limit - m_cnt;
    e.cnt  = m_cnt;
    e.run  = (m_mode == 1) ? 1 : 0;
    e.exp  = m_exp;
    e.tu   = (m_mode == 2) ? 1 : 0;
    e.warn = (m_mode == 1 && rem <= WARN) ? 1 : 0;
    return e;
  endfunction

  task automatic cyc(input bit st, input bit sp, input bit pa,
                     input bit cd, input int df);
    @(negedge clk);
    start = st; stop = sp; pause = pa; count_down = cd; difficulty = 2'(df);
    model_edge(st, sp, pa, cd, df);
    q.push_back(predict());
  endtask

  task automatic run_until(input int target, input bit cd, input int df);
    for (int i = 0; i < 600 && m_cnt != target; i++) cyc(0, 0, 0, cd, df);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_counter"}, int'(counter), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_expired"}, int'(expired), 0);
    chk({tag, "_time_up"}, int'(time_up), 0);
    chk({tag, "_warn"},    int'(warn),    0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && q.size() > 0) begin
        e = q.pop_front();
        chk("counter", int'(counter), e.cnt);
        chk("running", int'(running), e.run);
        chk("expired", int'(expired), e.exp);
        chk("time_up", int'(time_up), e.tu);
        chk("warn",    int'(warn),    e.warn);
      end
    end
  end

  initial begin
    bit pa;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    count_down = 1'b0; difficulty = 2'd0;
    model_reset();
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Up count on difficulty 1 through expiry, then hold in DONE.
    cyc(1, 0, 0, 0, 1);
    repeat (31 * TD + 4) cyc(0, 0, 0, 0, 1);

    // Down count on difficulty 0 with warning and expiry at zero.
    cyc(1, 0, 0, 1, 0);
    repeat (15 * TD + 4) cyc(0, 0, 0, 1, 0);

    // Pause for 10 cycles at counter 7, then finish the round.
    cyc(1, 0, 0, 1, 0);
    run_until(7, 1, 0);
    repeat (10) cyc(0, 0, 1, 1, 0);
    repeat (8 * TD + 4) cyc(0, 0, 0, 1, 0);

    // Restart at counter 20 with a new difficulty, start and stop together.
    cyc(1, 0, 0, 0, 1);
    run_until(20, 0, 1);
    cyc(1, 1, 0, 0, 2);
    repeat (20) cyc(0, 0, 0, 0, 2);

    // Stop at counter 9, idle, then a full round and a start from DONE.
    run_until(9, 0, 2);
    cyc(0, 1, 0, 0, 2);
    repeat (6) cyc(0, 0, 0, 0, 2);
    cyc(1, 0, 0, 0, 0);
    repeat (15 * TD + 3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (12) cyc(0, 0, 0, 1, 0);

    // Asynchronous reset mid-round, then zero-limit rounds both directions.
    async_reset();
    cyc(1, 0, 0, 0, 3);
    repeat (4) cyc(0, 0, 0, 0, 3);
    cyc(1, 0, 0, 1, 3);
    repeat (4) cyc(0, 0, 0, 1, 3);

    // Randomized traffic.
    pa = 1'b0;
    repeat (2000) begin
      if ($urandom_range(0, 15) == 0) pa = !pa;
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0), pa,
          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    cyc(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_round_timer
